icache: RTL and testbench

Direct-mapped, blocking instruction cache between the fetch stage and the memory-side cache controller. It serves 64-bit fetch blocks to fetch on a hit in the same cycle. On a miss it issues a single-block BUS_LOAD to the controller, retries until the request is accepted, and waits for the matching memory tag. It then fills the line, forwarding the returning data to fetch in the fill cycle.

---
 rtl/icache.sv | 109 ++++++++++
 tb/tb_icache.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache.sv
// Direct-mapped blocking instruction cache: same-cycle hits, a single outstanding
// BUS_LOAD on a miss, and bypass of the returning block to fetch in the fill cycle.
`ifndef XLEN
`define XLEN 32
`endif

module icache #(
    parameter int LINES = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [`XLEN-1:0]   proc2Icache_addr,
    output logic [63:0]        Icache2proc_data,
    output logic               Icache2proc_valid,
    output logic [1:0]         Icache2ctrl_command,
    output logic [`XLEN-1:0]   Icache2ctrl_addr,
    input  logic [3:0]         ctrl2Icache_response,
    input  logic [63:0]        ctrl2Icache_data,
    input  logic [3:0]         ctrl2Icache_tag
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = `XLEN - 3 - IDX_W;
    localparam int BLK_W = `XLEN - 3;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    typedef enum logic {IDLE, WAIT_DATA} state_t;

    state_t             state;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tags_q [LINES];
    logic [63:0]        data_q [LINES];
    logic [3:0]         pend_tag;
    logic [BLK_W-1:0]   pend_addr;

    logic [BLK_W-1:0]   blk;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   pend_idx;
    logic [TAG_W-1:0]   pend_line_tag;
    logic               hit;
    logic               fill;
    logic               bypass;
    logic               unused_offset;

    assign blk           = proc2Icache_addr[`XLEN-1:3];
    assign idx           = proc2Icache_addr[IDX_W+2:3];
    assign tag           = proc2Icache_addr[`XLEN-1:IDX_W+3];
    assign pend_idx      = pend_addr[IDX_W-1:0];
    assign pend_line_tag = pend_addr[BLK_W-1:IDX_W];
    assign unused_offset = ^proc2Icache_addr[2:0];

    assign hit    = valid_q[idx] && (tags_q[idx] == tag);
    // pend_tag is zero whenever nothing is outstanding, so a zero bus tag never fills
    assign fill   = (state == WAIT_DATA) && (pend_tag != 4'd0) && (ctrl2Icache_tag == pend_tag);
    assign bypass = fill && (blk == pend_addr);

    always_comb begin
        Icache2proc_valid   = 1'b0;
        Icache2proc_data    = data_q[idx];
        Icache2ctrl_command = BUS_NONE;
        Icache2ctrl_addr    = {blk, 3'b000};
        if (!reset) begin
            if (bypass) begin
                Icache2proc_valid = 1'b1;
                Icache2proc_data  = ctrl2Icache_data;
            end else if (hit) begin
                Icache2proc_valid = 1'b1;
            end
            if ((state == IDLE) && !hit)
                Icache2ctrl_command = BUS_LOAD;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            valid_q  <= '0;
            pend_tag <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (!hit && (ctrl2Icache_response != 4'd0)) begin
                        pend_tag  <= ctrl2Icache_response;
                        pend_addr <= blk;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (fill) begin
                        valid_q[pend_idx] <= 1'b1;
                        pend_tag          <= 4'd0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line contents need no reset; the valid bits alone guard them.
    always_ff @(posedge clock) begin
        if (!reset && fill) begin
            tags_q[pend_idx] <= pend_line_tag;
            data_q[pend_idx] <= ctrl2Icache_data;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus randomized fetch/bus traffic,
// checked against a line-array reference model of the cache.
module tb_icache;
    localparam int LINES = 32;
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [63:0] data_o;
    logic        valid_o;
    logic [1:0]  cmd;
    logic [31:0] caddr;
    logic [3:0]  resp;
    logic [63:0] cdata;
    logic [3:0]  ctag;

    icache #(.LINES(LINES)) dut (
        .clock                (clock),
        .reset                (reset),
        .proc2Icache_addr     (addr),
        .Icache2proc_data     (data_o),
        .Icache2proc_valid    (valid_o),
        .Icache2ctrl_command  (cmd),
        .Icache2ctrl_addr     (caddr),
        .ctrl2Icache_response (resp),
        .ctrl2Icache_data     (cdata),
        .ctrl2Icache_tag      (ctag)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model: one entry per line plus the single outstanding request
    bit          m_valid [LINES];
    int unsigned m_tag   [LINES];
    logic [63:0] m_data  [LINES];
    bit          m_wait;
    logic [3:0]  m_ptag;
    int unsigned m_pblk;

    logic        obs_valid;
    logic [63:0] obs_data;
    logic [1:0]  obs_cmd;
    logic [31:0] obs_addr;

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [63:0] memval(input int unsigned blk);
        return {blk * 32'h9E37_79B9, ~blk};
    endfunction

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic cycle(input logic [31:0] a, input logic [3:0] r, input logic [3:0] t,
                         input logic [63:0] d, input logic rs);
        int unsigned blk, idx, tg;
        bit hit, fill, byp;
        logic exp_valid;
        logic [63:0] exp_data;
        logic [1:0] exp_cmd;
        @(negedge clock);
        reset = rs; addr = a; resp = r; ctag = t; cdata = d;
        #1;
        blk  = int'(a >> 3);
        idx  = blk % LINES;
        tg   = blk / LINES;
        hit  = m_valid[idx] && (m_tag[idx] == tg);
        fill = m_wait && (t != 4'd0) && (t == m_ptag);
        byp  = fill && (blk == m_pblk);
        exp_valid = !rs && (hit || byp);
        exp_data  = byp ? d : m_data[idx];
        exp_cmd   = (!rs && !m_wait && !hit) ? BUS_LOAD : BUS_NONE;
        obs_valid = valid_o; obs_data = data_o; obs_cmd = cmd; obs_addr = caddr;
        check_eq("valid", valid_o, exp_valid);
        check_eq("command", cmd, exp_cmd);
        if (exp_valid) check_eq("data", data_o, exp_data);
        if (exp_cmd == BUS_LOAD) check_eq("req_addr", caddr, {a[31:3], 3'b000});
        if (rs) begin
            for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
            m_wait = 1'b0;
            m_ptag = 4'd0;
        end else if (!m_wait) begin
            if (!hit && r != 4'd0) begin
                m_wait = 1'b1; m_ptag = r; m_pblk = blk;
            end
        end else if (fill) begin
            m_valid[m_pblk % LINES] = 1'b1;
            m_tag[m_pblk % LINES]   = m_pblk / LINES;
            m_data[m_pblk % LINES]  = d;
            m_wait = 1'b0;
            m_ptag = 4'd0;
        end
    endtask

    task automatic idle(input logic [31:0] a);
        cycle(a, 4'd0, 4'd0, 64'd0, 1'b0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [3:0]  rt, rr;
        logic [63:0] rd;
        int cnt, lat;
        bit was_wait;

        m_wait = 1'b0; m_ptag = 4'd0; m_pblk = 0;
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_data[i] = '0;
        end

        cycle(32'h0, 4'd0, 4'd0, 64'd0, 1'b1);
        cycle(32'h0, 4'd0, 4'd0, 64'd0, 1'b1);
        check_eq("rst_cmd", obs_cmd, BUS_NONE);
        check_eq("rst_valid", obs_valid, 1'b0);

        // cold miss with immediate acceptance and bypass on the tag cycle
        cycle(32'h40, 4'd3, 4'd0, 64'd0, 1'b0);
        check_eq("cold_cmd", obs_cmd, BUS_LOAD);
        check_eq("cold_addr", obs_addr, 32'h40);
        for (int i = 0; i < 4; i++) begin
            idle(32'h40);
            check_eq("cold_wait_cmd", obs_cmd, BUS_NONE);
        end
        cycle(32'h44, 4'd0, 4'd3, 64'h1122334455667788, 1'b0);
        check_eq("cold_bypass", obs_data, 64'h1122334455667788);
        idle(32'h40);
        check_eq("cold_hit", obs_valid, 1'b1);
        check_eq("cold_hit_cmd", obs_cmd, BUS_NONE);

        // rejection: request held until accepted
        for (int i = 0; i < 3; i++) begin
            cycle(32'h48, 4'd0, 4'd0, 64'd0, 1'b0);
            check_eq("rej_cmd", obs_cmd, BUS_LOAD);
        end
        cycle(32'h48, 4'd7, 4'd0, 64'd0, 1'b0);
        check_eq("rej_accept_cmd", obs_cmd, BUS_LOAD);
        idle(32'h48);
        check_eq("rej_after_cmd", obs_cmd, BUS_NONE);
        cycle(32'h48, 4'd0, 4'd7, 64'hA5A5_0000_1234_5678, 1'b0);
        check_eq("rej_fill", obs_valid, 1'b1);

        // foreign tag is ignored
        cycle(32'h50, 4'd3, 4'd0, 64'd0, 1'b0);
        cycle(32'h50, 4'd0, 4'd5, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0);
        check_eq("foreign_valid", obs_valid, 1'b0);
        idle(32'h50);
        check_eq("foreign_nowrite", obs_valid, 1'b0);
        cycle(32'h50, 4'd0, 4'd3, 64'h0BAD_F00D_CAFE_0001, 1'b0);
        idle(32'h50);
        check_eq("foreign_fill", obs_data, 64'h0BAD_F00D_CAFE_0001);

        // conflict on index 0
        cycle(32'h000, 4'd1, 4'd0, 64'd0, 1'b0);
        cycle(32'h000, 4'd0, 4'd1, memval(0), 1'b0);
        cycle(32'h100, 4'd2, 4'd0, 64'd0, 1'b0);
        check_eq("conf_cmd", obs_cmd, BUS_LOAD);
        cycle(32'h100, 4'd0, 4'd2, memval(32), 1'b0);
        idle(32'h100);
        check_eq("conf_hit", obs_valid, 1'b1);
        idle(32'h000);
        check_eq("conf_miss", obs_valid, 1'b0);
        check_eq("conf_reload", obs_addr, 32'h000);

        // reset while waiting abandons the transaction
        cycle(32'h000, 4'd0, 4'd0, 64'd0, 1'b0);
        cycle(32'h60, 4'd3, 4'd0, 64'd0, 1'b0);
        cycle(32'h60, 4'd0, 4'd0, 64'd0, 1'b1);
        cycle(32'h60, 4'd0, 4'd3, 64'h5555_6666_7777_8888, 1'b0);
        check_eq("rstmid_reissue", obs_cmd, BUS_LOAD);
        idle(32'h60);
        check_eq("rstmid_nofill", obs_valid, 1'b0);
        idle(32'h40);
        check_eq("rstmid_old_miss", obs_valid, 1'b0);

        // fetch address moves while waiting
        cycle(32'h40, 4'd2, 4'd0, 64'd0, 1'b0);
        idle(32'h80);
        cycle(32'h80, 4'd0, 4'd2, 64'h0123_4567_89AB_CDEF, 1'b0);
        check_eq("move_nobypass", obs_valid, 1'b0);
        check_eq("move_fill_cmd", obs_cmd, BUS_NONE);
        idle(32'h80);
        check_eq("move_issue", obs_cmd, BUS_LOAD);
        idle(32'h40);
        check_eq("move_hit_data", obs_data, 64'h0123_4567_89AB_CDEF);

        // randomized traffic with a behavioural memory controller
        cnt = 0; lat = 1;
        ra = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 3)
                ra = (($urandom_range(0, 2) * LINES + $urandom_range(0, 3)) << 3) | ($urandom & 32'h7);
            rr = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            rt = 4'd0;
            rd = {$urandom, $urandom};
            if (m_wait) begin
                cnt++;
                if (cnt >= lat) begin
                    rt = m_ptag;
                    rd = memval(m_pblk);
                end else if ($urandom_range(0, 3) == 0) begin
                    rt = m_ptag ^ 4'($urandom_range(1, 15));
                end
            end else begin
                rt = 4'($urandom_range(0, 15));
            end
            was_wait = m_wait;
            cycle(ra, rr, rt, rd, ($urandom_range(0, 63) == 0));
            if (!was_wait && m_wait) begin
                cnt = 0;
                lat = $urandom_range(1, 5);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
